// File: rtl/booth_mul_32.sv
// booth_mul_32 -- sequential radix-4 Booth multiplier, 32x32 -> 64 (HI/LO).
// One Booth partial product is accumulated per clock into a 66-bit sum.
// Optional feature macro: BOOTH_UNSIGNED_EN adds the mul_unsigned port and
// the 17th iteration needed for a zero-extended unsigned multiplier.
module booth_mul_32 (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
`ifdef BOOTH_UNSIGNED_EN
  input  logic        mul_unsigned,
`endif
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [65:0] r_acc;
  logic [65:0] r_mcand;
  logic [34:0] r_mplr;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_extA;
  logic        w_extB;
  logic [4:0]  w_last;
  logic [2:0]  w_trip;
  logic [65:0] w_mag;
  logic        w_neg;
  logic [65:0] w_addend;
  logic [65:0] w_sum;

`ifdef BOOTH_UNSIGNED_EN
  logic        r_unsigned;

  // Operand extension follows the requested mode; unsigned needs one extra step.
  always_comb begin
    w_extA = a[31] & ~mul_unsigned;
    w_extB = b[31] & ~mul_unsigned;
    w_last = r_unsigned ? 5'd16 : 5'd15;
  end
`else
  // Signed-only build: operands are always sign-extended, 16 steps.
  always_comb begin
    w_extA = a[31];
    w_extB = b[31];
    w_last = 5'd15;
  end
`endif

  // Recode the low multiplier triplet into 0, +-A, +-2A and add it to the sum.
  always_comb begin
    w_trip = r_mplr[2:0];
    w_mag  = '0;
    w_neg  = 1'b0;
    case (w_trip)
      3'b001, 3'b010: w_mag = r_mcand;
      3'b011:         w_mag = {r_mcand[64:0], 1'b0};
      3'b100: begin
        w_mag = {r_mcand[64:0], 1'b0};
        w_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        w_mag = r_mcand;
        w_neg = 1'b1;
      end
      default: begin
        w_mag = '0;
        w_neg = 1'b0;
      end
    endcase
    w_addend = w_neg ? ~w_mag : w_mag;
    w_sum    = r_acc + w_addend + {65'd0, w_neg};
  end

  // Control FSM plus datapath registers; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
`ifdef BOOTH_UNSIGNED_EN
      r_unsigned <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_mcand <= {{34{w_extA}}, a};
            r_mplr  <= {w_extB, w_extB, b, 1'b0};
`ifdef BOOTH_UNSIGNED_EN
            r_unsigned <= mul_unsigned;
`endif
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc   <= w_sum;
          r_mcand <= {r_mcand[63:0], 2'b00};
          r_mplr  <= {2'b00, r_mplr[34:2]};
          if (r_cnt == w_last) begin
            r_hi    <= w_sum[63:32];
            r_lo    <= w_sum[31:0];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_booth_mul_32.sv
// tb_booth_mul_32 -- scoreboard bench for booth_mul_32 using directed vectors.
// Define BOOTH_UNSIGNED_EN for both files to also exercise unsigned mode.
module tb_booth_mul_32;

  logic        clk;
  logic        clr;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        mulUnsigned;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          doneCyc;
    int          busyLen;
  } exp_t;

  exp_t sbQ[$];

  booth_mul_32 dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .a            (a),
    .b            (b),
`ifdef BOOTH_UNSIGNED_EN
    .mul_unsigned (mulUnsigned),
`endif
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so latency can be checked against issue time.
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something wedges the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Drive one start pulse; optionally push the expected result to the scoreboard.
  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic uns,
                               input bit pushExp, input logic [31:0] eHi, input logic [31:0] eLo);
    exp_t e;
    int n;
    @(negedge clk);
    a = ia;
    b = ib;
    mulUnsigned = uns;
    start = 1'b1;
    n = uns ? 17 : 16;
    if (pushExp) begin
      e.hi = eHi;
      e.lo = eLo;
      e.doneCyc = cyc + 1 + n;
      e.busyLen = n;
      sbQ.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for done; returns at the negedge where done is seen.
  task automatic waitDone(output bit seen);
    int i;
    seen = 1'b0;
    i = 0;
    while (!seen && i < 100) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      i++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no done in 100 cycles required done");
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a result.
  initial begin : monitor
    int busyCnt;
    exp_t e;
    busyCnt = 0;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d required no done", cyc);
        end else begin
          e = sbQ.pop_front();
          checkOutput("hi", {32'd0, hi}, {32'd0, e.hi});
          checkOutput("lo", {32'd0, lo}, {32'd0, e.lo});
          checkOutput("done_cycle", 64'(cyc), 64'(e.doneCyc));
          checkOutput("busy_len", 64'(busyCnt), 64'(e.busyLen));
        end
        busyCnt = 0;
      end else if (busy) begin
        busyCnt++;
      end else begin
        busyCnt = 0;
      end
    end
  end

  logic [31:0] vecA  [7] = '{32'h00000007, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
                             32'h00000000, 32'h12345678, 32'hFFFFFFFF};
  logic [31:0] vecB  [7] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
                             32'hDEADBEEF, 32'h00000010, 32'h7FFFFFFF};
  logic [31:0] vecHi [7] = '{32'hFFFFFFFF, 32'h40000000, 32'hC0000000, 32'h00000000,
                             32'h00000000, 32'h00000001, 32'hFFFFFFFF};
  logic [31:0] vecLo [7] = '{32'hFFFFFFEB, 32'h00000000, 32'h80000000, 32'h00000001,
                             32'h00000000, 32'h23456780, 32'h80000001};

  // Main stimulus sequence.
  initial begin : stim
    bit seen;
    clr = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    mulUnsigned = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_done", {63'd0, done}, 64'd0);
    checkOutput("reset_hi", {32'd0, hi}, 64'd0);
    checkOutput("reset_lo", {32'd0, lo}, 64'd0);
    clr = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecA[i], vecB[i], 1'b0, 1'b1, vecHi[i], vecLo[i]);
      waitDone(seen);
    end

    // Starts during RUN and DONE must be ignored; results held until completion.
    applyStimulus(32'd3, 32'd5, 1'b0, 1'b1, 32'd0, 32'd15);
    checkOutput("hold_hi", {32'd0, hi}, 64'h00000000FFFFFFFF);
    checkOutput("hold_lo", {32'd0, lo}, 64'h0000000080000001);
    repeat (3) @(negedge clk);
    a = 32'd9;
    b = 32'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(seen);
    if (seen) begin
      a = 32'd9;
      b = 32'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_done_start", {63'd0, busy}, 64'd0);
      @(negedge clk);
      checkOutput("still_idle", {63'd0, busy}, 64'd0);
    end

    // clr mid-RUN aborts: outputs return to reset values, no done pulse.
    applyStimulus(32'h12345678, 32'h00000010, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr_busy", {63'd0, busy}, 64'd0);
    checkOutput("clr_done", {63'd0, done}, 64'd0);
    checkOutput("clr_hi", {32'd0, hi}, 64'd0);
    checkOutput("clr_lo", {32'd0, lo}, 64'd0);
    repeat (30) @(negedge clk);
    checkOutput("clr_no_restart", {63'd0, busy}, 64'd0);

`ifdef BOOTH_UNSIGNED_EN
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000001);
    waitDone(seen);
    applyStimulus(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000, 32'h00000001);
    waitDone(seen);
`endif

    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", 64'(sbQ.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
